// File: rtl/afpm_pkg.sv
// Shared types and constants for the FP16 multiplier sequencer.
// Holds the FSM state encoding and FP16 result constants.
package afpm_pkg;

    localparam int FP16_W = 16;
    localparam logic [FP16_W-1:0] QNAN = 16'h7E00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_HI,
        S_ISSUE,
        S_WAIT,
        S_OUT_LO,
        S_OUT_HI
    } state_e;

endpackage

// File: rtl/afpm_wait_timer.sv
// WAIT-state cycle counter for the multiplier sequencer.
// expired marks the TIMEOUT_CYC-th enabled cycle since the last clr.
module afpm_wait_timer #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // next count: clear wins, otherwise count while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // expiry flag for the current enabled cycle
    always_comb begin
        expired = en && (cnt_q == LAST);
    end

endmodule

// File: rtl/afpm_seq_ctrl.sv
// Byte-serial front end for an FP16 multiplier core.
// Gathers two operands, issues one multiply, streams the product out.
module afpm_seq_ctrl
    import afpm_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        a_byte,
    input  logic [7:0]        b_byte,
    output logic              in_ready,
    output logic [FP16_W-1:0] mul_a,
    output logic [FP16_W-1:0] mul_b,
    output logic              mul_start,
    input  logic              mul_done,
    input  logic [FP16_W-1:0] mul_result,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              timeout
);

    state_e            state_q, state_d;
    logic [FP16_W-1:0] mul_a_q, mul_a_d;
    logic [FP16_W-1:0] mul_b_q, mul_b_d;
    logic [FP16_W-1:0] res_q, res_d;
    logic              timeout_q, timeout_d;
    logic              accept;
    logic              tmr_clr;
    logic              tmr_en;
    logic              tmr_expired;

    afpm_wait_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // state and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            res_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            res_q     <= res_d;
            timeout_q <= timeout_d;
        end
    end

    // next-state logic; mul_done beats expiry in WAIT
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (accept) state_d = S_LOAD_HI;
            S_LOAD_HI: if (accept) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT:    if (mul_done || tmr_expired) state_d = S_OUT_LO;
            S_OUT_LO:  if (out_ready) state_d = S_OUT_HI;
            S_OUT_HI:  if (out_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Moore outputs and timer controls
    always_comb begin
        in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD_HI);
        mul_start = (state_q == S_ISSUE);
        out_valid = (state_q == S_OUT_LO) || (state_q == S_OUT_HI);
        busy      = (state_q != S_IDLE);
        tmr_clr   = (state_q == S_ISSUE);
        tmr_en    = (state_q == S_WAIT);
        out_byte  = 8'h00;
        if (state_q == S_OUT_LO) out_byte = res_q[7:0];
        if (state_q == S_OUT_HI) out_byte = res_q[15:8];
    end

    // operand capture, result capture and sticky timeout
    always_comb begin
        accept    = in_valid && in_ready;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        res_d     = res_q;
        timeout_d = timeout_q;
        if (accept && state_q == S_IDLE) begin
            mul_a_d[7:0] = a_byte;
            mul_b_d[7:0] = b_byte;
            timeout_d    = 1'b0;
        end
        if (accept && state_q == S_LOAD_HI) begin
            mul_a_d[15:8] = a_byte;
            mul_b_d[15:8] = b_byte;
        end
        if (state_q == S_WAIT) begin
            if (mul_done) begin
                res_d = mul_result;
            end else if (tmr_expired) begin
                res_d     = QNAN;
                timeout_d = 1'b1;
            end
        end
    end

    assign mul_a   = mul_a_q;
    assign mul_b   = mul_b_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_afpm_seq_ctrl.sv
// Self-checking bench for afpm_seq_ctrl.
// Directed and random operations against a transaction-level model.
module tb_afpm_seq_ctrl;

    localparam int T = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  a_byte = 8'h00;
    logic [7:0]  b_byte = 8'h00;
    logic        in_ready;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic        mul_start;
    logic        mul_done = 1'b0;
    logic [15:0] mul_result = 16'h0000;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        timeout;

    int total = 0;
    int bad = 0;
    logic last_to = 1'b0;

    afpm_seq_ctrl #(.TIMEOUT_CYC(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .a_byte     (a_byte),
        .b_byte     (b_byte),
        .in_ready   (in_ready),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_start  (mul_start),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // noise on the core handshake outside WAIT must be ignored
    task automatic noise();
        mul_done   = 1'($urandom);
        mul_result = 16'($urandom);
    endtask

    // One full operation. d = WAIT cycle (1-based) on which the stub core
    // raises mul_done; 0 means never. Expected values come from the rule:
    // a done inside the first T WAIT cycles wins, otherwise qNaN + timeout.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] core, input int d,
                          input int gap, input int bp_lo, input int bp_hi);
        logic [15:0] exp_r;
        logic        exp_to;
        int          n_wait;
        logic        got;
        exp_to = !(d >= 1 && d <= T);
        exp_r  = exp_to ? 16'h7E00 : core;
        @(negedge clk);
        chk("idle_busy", 16'(busy), 16'd0);
        chk("idle_rdy", 16'(in_ready), 16'd1);
        chk("to_sticky", 16'(timeout), 16'(last_to));
        in_valid = 1'b1;
        a_byte   = a[7:0];
        b_byte   = b[7:0];
        out_ready = 1'b0;
        noise();
        @(negedge clk);
        chk("lohi_busy", 16'(busy), 16'd1);
        chk("to_clr", 16'(timeout), 16'd0);
        chk("lo_a", 16'(mul_a[7:0]), 16'(a[7:0]));
        chk("lo_b", 16'(mul_b[7:0]), 16'(b[7:0]));
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            a_byte   = 8'($urandom);
            b_byte   = 8'($urandom);
            noise();
            @(negedge clk);
            chk("gap_rdy", 16'(in_ready), 16'd1);
            chk("gap_start", 16'(mul_start), 16'd0);
        end
        in_valid = 1'b1;
        a_byte   = a[15:8];
        b_byte   = b[15:8];
        noise();
        @(negedge clk);
        in_valid = 1'b0;
        a_byte   = 8'($urandom);
        b_byte   = 8'($urandom);
        chk("start", 16'(mul_start), 16'd1);
        chk("issue_rdy", 16'(in_ready), 16'd0);
        chk("mul_a", mul_a, a);
        chk("mul_b", mul_b, b);
        noise();
        n_wait = 0;
        got    = 1'b0;
        for (int c = 0; c < T + 4; c++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            n_wait++;
            chk("wait_start", 16'(mul_start), 16'd0);
            mul_done   = (d == n_wait);
            mul_result = (d == n_wait) ? core : 16'($urandom);
        end
        chk("out_seen", 16'(got), 16'd1);
        chk("wait_cyc", 16'(n_wait), exp_to ? 16'(T) : 16'(d));
        for (int i = 0; i < bp_lo; i++) begin
            out_ready = 1'b0;
            noise();
            chk("bp_lo_v", 16'(out_valid), 16'd1);
            chk("bp_lo_b", 16'(out_byte), 16'(exp_r[7:0]));
            @(negedge clk);
        end
        chk("lo_v", 16'(out_valid), 16'd1);
        chk("lo_byte", 16'(out_byte), 16'(exp_r[7:0]));
        chk("hold_a", mul_a, a);
        out_ready = 1'b1;
        noise();
        @(negedge clk);
        for (int i = 0; i < bp_hi; i++) begin
            out_ready = 1'b0;
            noise();
            chk("bp_hi_v", 16'(out_valid), 16'd1);
            chk("bp_hi_b", 16'(out_byte), 16'(exp_r[15:8]));
            @(negedge clk);
        end
        chk("hi_v", 16'(out_valid), 16'd1);
        chk("hi_byte", 16'(out_byte), 16'(exp_r[15:8]));
        chk("hold_b", mul_b, b);
        out_ready = 1'b1;
        noise();
        @(negedge clk);
        out_ready = 1'b0;
        mul_done  = 1'b0;
        chk("end_busy", 16'(busy), 16'd0);
        chk("end_v", 16'(out_valid), 16'd0);
        chk("timeout", 16'(timeout), 16'(exp_to));
        last_to = exp_to;
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_start", 16'(mul_start), 16'd0);
        chk("rst_ov", 16'(out_valid), 16'd0);
        chk("rst_ob", 16'(out_byte), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_to", 16'(timeout), 16'd0);
        chk("rst_a", mul_a, 16'd0);
        chk("rst_b", mul_b, 16'd0);
        chk("rst_rdy", 16'(in_ready), 16'd1);
        rst = 1'b0;

        run_op(16'h3E00, 16'h4200, 16'h4480, 3, 0, 0, 0);
        run_op(16'h3C00, 16'h4000, 16'h1111, 0, 0, 0, 0);
        run_op(16'h3E00, 16'h4200, 16'h4480, 2, 0, 5, 0);
        run_op(16'h1234, 16'h5678, 16'hBEEF, T, 0, 0, 2);
        run_op(16'hAAAA, 16'h5555, 16'hCAFE, T + 1, 0, 1, 1);
        run_op(16'h3E00, 16'h4200, 16'h4480, 1, 4, 0, 0);
        run_op(16'h0102, 16'h0304, 16'h0506, 1, 0, 0, 0);

        // reset while waiting on the core
        @(negedge clk);
        in_valid = 1'b1;
        a_byte   = 8'h11;
        b_byte   = 8'h22;
        @(negedge clk);
        a_byte   = 8'h33;
        b_byte   = 8'h44;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rm_start", 16'(mul_start), 16'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        mul_done   = 1'b1;
        mul_result = 16'h1234;
        chk("rm_busy", 16'(busy), 16'd0);
        chk("rm_ov", 16'(out_valid), 16'd0);
        chk("rm_a", mul_a, 16'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mul_done = 1'b0;
            chk("rm_late_ov", 16'(out_valid), 16'd0);
            chk("rm_late_st", 16'(mul_start), 16'd0);
            chk("rm_late_bz", 16'(busy), 16'd0);
        end
        last_to = 1'b0;

        for (int k = 0; k < 20; k++) begin
            run_op(16'($urandom), 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, T + 3)),
                   int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
